// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - op codes, FSM states and operand classifiers for muldiv_unit
package muldiv_unit_pkg;

  // funct3 encodings of the RV32M instructions
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // rs1 is interpreted as signed; MUL is handled unsigned because its low half is sign-agnostic
  function automatic logic a_is_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is interpreted as signed (MULHSU treats rs2 as unsigned)
  function automatic logic b_is_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit with kill and divide special cases
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int               CNT_W    = $clog2(XLEN);
  localparam int               AW       = 2 * XLEN;
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  md_state_e        state_q;
  md_state_e        state_n;
  logic [CNT_W-1:0] cnt_q;
  // multiply: {partial product high, multiplier / product low}
  // divide:   {partial remainder, dividend / quotient}
  logic [AW-1:0]    acc_q;
  logic [XLEN-1:0]  opnd_q;      // multiplicand or divisor magnitude
  logic [2:0]       op_q;
  logic             neg_q;       // final result must be negated
  logic [XLEN-1:0]  result_q;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [XLEN-1:0]  a_abs;
  logic [XLEN-1:0]  b_abs;
  logic             neg_in;
  logic             b_zero;
  logic             sgn_ovf;
  logic             special;
  logic [XLEN-1:0]  special_val;

  logic [XLEN:0]    hi_sum;
  logic [XLEN:0]    rem_shift;
  logic [XLEN:0]    rem_diff;
  logic [AW-1:0]    mul_next;
  logic [AW-1:0]    div_next;
  logic [AW-1:0]    step_next;
  logic [AW-1:0]    prod_signed;
  logic [XLEN-1:0]  quo_fin;
  logic [XLEN-1:0]  rem_fin;
  logic [XLEN-1:0]  final_val;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [AW-1:0] neg_2x(input logic [AW-1:0] v);
    return ~v + AW'(1);
  endfunction

  assign accept = start && !kill && (state_q != MD_CALC);

  // Accept-time operand magnitudes, result sign and divide special cases
  always_comb begin
    a_neg   = a_is_signed(op) && a[XLEN-1];
    b_neg   = b_is_signed(op) && b[XLEN-1];
    a_abs   = a_neg ? neg_x(a) : a;
    b_abs   = b_neg ? neg_x(b) : b;
    neg_in  = (op == MD_REM) ? a_neg : (a_neg ^ b_neg);
    b_zero  = (b == '0);
    sgn_ovf = (a == INT_MIN) && (b == '1) && !op[0];
    special = op[2] && (b_zero || sgn_ovf);
    if (b_zero) begin
      special_val = op[1] ? a : '1;
    end else begin
      special_val = op[1] ? '0 : a;
    end
  end

  // One radix-2 iteration of the shared shift datapath plus final sign fix-up
  always_comb begin
    hi_sum      = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next    = {hi_sum, acc_q[XLEN-1:1]};
    rem_shift   = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
    rem_diff    = rem_shift - {1'b0, opnd_q};
    if (rem_diff[XLEN]) begin
      div_next = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    step_next   = op_q[2] ? div_next : mul_next;
    prod_signed = neg_q ? neg_2x(mul_next) : mul_next;
    quo_fin     = neg_q ? neg_x(div_next[XLEN-1:0]) : div_next[XLEN-1:0];
    rem_fin     = neg_q ? neg_x(div_next[AW-1:XLEN]) : div_next[AW-1:XLEN];
    if (op_q[2]) begin
      final_val = op_q[1] ? rem_fin : quo_fin;
    end else if (op_q == MD_MUL) begin
      final_val = prod_signed[XLEN-1:0];
    end else begin
      final_val = prod_signed[AW-1:XLEN];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state: kill wins over everything, special cases skip CALC
  always_comb begin
    state_n = state_q;
    if (kill) begin
      state_n = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE, MD_DONE: begin
          if (accept) begin
            state_n = special ? MD_DONE : MD_CALC;
          end else begin
            state_n = MD_IDLE;
          end
        end
        MD_CALC: begin
          if (cnt_q == '0) begin
            state_n = MD_DONE;
          end
        end
        default: state_n = MD_IDLE;
      endcase
    end
  end

  // Datapath: load on accept, iterate in CALC, capture result on entry to DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (!kill) begin
      if (accept) begin
        op_q   <= op;
        neg_q  <= neg_in;
        cnt_q  <= CNT_LAST;
        acc_q  <= {{XLEN{1'b0}}, a_abs};
        opnd_q <= b_abs;
        if (special) begin
          result_q <= special_val;
        end
      end else if (state_q == MD_CALC) begin
        acc_q <= step_next;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          result_q <= final_val;
        end
      end
    end
  end

  assign busy   = (state_q == MD_CALC);
  assign done   = (state_q == MD_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized and directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_errors;
  logic cmp_en;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: {special, value}; special = answered without iterating
  function automatic logic [32:0] ref_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    int          ix, iy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    ix = int'($signed(x));
    iy = int'($signed(y));
    case (o)
      3'd0: begin p = 64'(ux * uy); return {1'b0, p[31:0]}; end
      3'd1: begin p = 64'(sx * sy); return {1'b0, p[63:32]}; end
      3'd2: begin p = 64'(sx * uy); return {1'b0, p[63:32]}; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return {1'b0, p[63:32]}; end
      3'd4: begin
        if (y == 32'd0) return {1'b1, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b1, x};
        return {1'b0, 32'(ix / iy)};
      end
      3'd5: begin
        if (y == 32'd0) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, x / y};
      end
      3'd6: begin
        if (y == 32'd0) return {1'b1, x};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b1, 32'd0};
        return {1'b0, 32'(ix % iy)};
      end
      default: begin
        if (y == 32'd0) return {1'b1, x};
        return {1'b0, x % y};
      end
    endcase
  endfunction

  // Behavioural model: an accepted op answers immediately (special) or after XLEN busy cycles
  logic        m_busy, m_done;
  logic [31:0] m_result, m_pend;
  int          m_left;
  logic [32:0] m_ref;

  assign m_ref = ref_calc(op, a, b);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_result <= 32'd0;
      m_pend   <= 32'd0;
      m_left   <= 0;
    end else if (kill) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (!m_busy && start) begin
      if (m_ref[32]) begin
        m_done   <= 1'b1;
        m_busy   <= 1'b0;
        m_result <= m_ref[31:0];
      end else begin
        m_done <= 1'b0;
        m_busy <= 1'b1;
        m_left <= XLEN;
        m_pend <= m_ref[31:0];
      end
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy   <= 1'b0;
        m_done   <= 1'b1;
        m_result <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("cmp_busy", {31'b0, busy}, {31'b0, m_busy});
      check("cmp_done", {31'b0, done}, {31'b0, m_done});
      check("cmp_result", result, m_result);
    end
  end

  function automatic logic [31:0] gen_operand();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, measure done latency (edges after the accept edge), check result literal and model
  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(lat));
    check({name, "_result"}, result, exp);
    check({name, "_model"}, m_result, exp);
  endtask

  initial begin
    int n;
    int dones;
    n_checks = 0;
    n_errors = 0;
    cmp_en = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    kill = 1'b0;
    op = 3'd0;
    a = 32'd0;
    b = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, XLEN);
    do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, XLEN);
    do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, XLEN);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, XLEN);
    do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, XLEN);
    do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, XLEN);
    do_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, XLEN);
    do_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, XLEN);
    do_op("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    do_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, 0);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // kill sampled at the tenth edge after accept: no done, result kept
    do_op("pre_kill", 3'd5, 32'd100, 32'd7, 32'd14, XLEN);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("kill_no_done", 32'(dones), 32'd0);
    check("kill_result_kept", result, 32'd14);

    // start pulsed while busy is ignored
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (n == 4) begin
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("ignore_latency", 32'(n), 32'(XLEN));
    check("ignore_result", result, 32'd14);

    // back-to-back start in the DONE cycle
    do_op("b2b_first", 3'd7, 32'd100, 32'd7, 32'd2, XLEN);
    start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!done && n < 100);
    check("b2b_gap", 32'(n), 32'(XLEN + 1));
    check("b2b_result", result, 32'd0);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("areset_busy", {31'b0, busy}, 32'd0);
    check("areset_done", {31'b0, done}, 32'd0);
    check("areset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_reset_divu", 3'd5, 32'd9, 32'd3, 32'd3, XLEN);

    // randomized traffic, checked every cycle against the model
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      kill  = ($urandom_range(0, 79) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = gen_operand();
      b     = gen_operand();
    end
    @(negedge clk);
    start = 1'b0;
    kill  = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
